// File: rtl/branch_predict_npc.sv
// Next-PC unit: BTB + 2-bit BHT prediction at IF, branch/jump resolution at EX,
// flush/redirect on mispredict, and a saturating mispredict counter.
module branch_predict_npc #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_if,
    input  logic            stall_if,
    output logic            pred_taken_if,
    output logic [XLEN-1:0] pred_target_if,
    output logic [XLEN-1:0] npc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_br,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [1:0]      ex_cmp,
    input  logic [1:0]      ex_cmp_u,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispredict_cnt
);

    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]   btb_tag_q [ENTRIES];
    logic [TAG_W-1:0]   btb_tag_d [ENTRIES];
    logic [XLEN-1:0]    btb_tgt_q [ENTRIES];
    logic [XLEN-1:0]    btb_tgt_d [ENTRIES];
    logic [1:0]         bht_q     [ENTRIES];
    logic [1:0]         bht_d     [ENTRIES];
    logic [31:0]        cnt_q, cnt_d;

    // ---------------- IF-stage prediction ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    always_comb begin
        if_idx         = pc_if[IDX_W+1:2];
        if_tag         = pc_if[XLEN-1:IDX_W+2];
        if_hit         = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
        pred_taken_if  = if_hit && bht_q[if_idx][1];
        pred_target_if = pred_taken_if ? btb_tgt_q[if_idx] : pc_if + PC_STEP;
    end

    // ---------------- EX-stage resolution ----------------
    logic             br_cond;
    logic             act_taken;
    logic [XLEN-1:0]  act_target;
    logic             mispredict;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;

    always_comb begin
        br_cond = 1'b0;
        case (ex_funct3)
            F3_BEQ:  br_cond = (ex_cmp == CMP_EQ);
            F3_BNE:  br_cond = (ex_cmp != CMP_EQ);
            F3_BLT:  br_cond = (ex_cmp == CMP_LT);
            F3_BGE:  br_cond = (ex_cmp == CMP_EQ) || (ex_cmp == CMP_GT);
            F3_BLTU: br_cond = (ex_cmp_u == CMP_LT);
            F3_BGEU: br_cond = (ex_cmp_u == CMP_EQ) || (ex_cmp_u == CMP_GT);
            default: br_cond = 1'b0;
        endcase

        act_taken = (ex_is_br && br_cond) || ex_is_jal || ex_is_jalr;

        if (ex_is_jalr) begin
            act_target = (ex_rs1 + ex_imm) & ~XLEN'(1);
        end else if (act_taken) begin
            act_target = ex_pc + (ex_imm << 1);
        end else begin
            act_target = ex_pc + PC_STEP;
        end

        // Target only matters when actually taken; a not-taken match is enough otherwise.
        mispredict = ex_valid &&
                     ((act_taken != ex_pred_taken) ||
                      (act_taken && (act_target != ex_pred_target)));

        ex_idx = ex_pc[IDX_W+1:2];
        ex_tag = ex_pc[XLEN-1:IDX_W+2];
    end

    always_comb begin
        flush       = mispredict;
        redirect_pc = act_target;
        if (flush) begin
            npc = redirect_pc;
        end else if (stall_if) begin
            npc = pc_if;
        end else begin
            npc = pred_target_if;
        end
        mispredict_cnt = cnt_q;
    end

    // ---------------- Table and counter update ----------------
    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        bht_d       = bht_q;

        if (ex_valid) begin
            if (ex_is_br) begin
                if (br_cond && bht_q[ex_idx] != 2'b11) begin
                    bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
                end else if (!br_cond && bht_q[ex_idx] != 2'b00) begin
                    bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
                end
            end else if (ex_is_jal || ex_is_jalr) begin
                bht_d[ex_idx] = 2'b11;
            end

            if (act_taken) begin
                btb_valid_d[ex_idx] = 1'b1;
                btb_tag_d[ex_idx]   = ex_tag;
                btb_tgt_d[ex_idx]   = act_target;
            end
        end

        cnt_d = cnt_q;
        if (mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid_q <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                bht_q[i]     <= 2'b01;
            end
        end else begin
            btb_valid_q <= btb_valid_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_tag_q[i] <= btb_tag_d[i];
                btb_tgt_q[i] <= btb_tgt_d[i];
                bht_q[i]     <= bht_d[i];
            end
        end
    end

endmodule
